// File: rtl/adsr_envelope_if.sv
// adsr_envelope_if: gate, envelope shape, master volume and envelope outputs
interface adsr_envelope_if;
  logic       gate_i;
  logic [7:0] attack_step_i;
  logic [7:0] decay_step_i;
  logic [7:0] sustain_lvl_i;
  logic [7:0] release_step_i;
  logic [7:0] master_vol_i;
  logic [7:0] volume_o;
  logic       active_o;
  logic [2:0] state_o;
  modport master (
    output gate_i, attack_step_i, decay_step_i, sustain_lvl_i, release_step_i, master_vol_i,
    input  volume_o, active_o, state_o
  );
  modport slave (
    input  gate_i, attack_step_i, decay_step_i, sustain_lvl_i, release_step_i, master_vol_i,
    output volume_o, active_o, state_o
  );
endinterface

// File: rtl/adsr_envelope.sv
// adsr_envelope: tick-paced ADSR level generator with master volume scaling
module adsr_envelope #(
  parameter int CLK_MHZ = 50,
  parameter int TICK_HZ = 1000
) (
  input logic            clk_i,
  input logic            rst_ni,
  adsr_envelope_if.slave bus
);
  localparam int TICK_DIV = CLK_MHZ * 1_000_000 / TICK_HZ;
  localparam int CW = $clog2(TICK_DIV);
  typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} state_t;
  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [7:0]    level, level_n;
  logic          gate_q, tick, rise, fall;
  logic [8:0]    att_sum, dec_diff, rel_diff;
  logic [16:0]   prod;
  logic          att_full, dec_done, rel_done;
  assign tick     = cnt == CW'(TICK_DIV - 1);
  assign rise     = bus.gate_i & ~gate_q;
  assign fall     = ~bus.gate_i & gate_q;
  assign att_sum  = {1'b0, level} + {1'b0, bus.attack_step_i};
  assign dec_diff = {1'b0, level} - {1'b0, bus.decay_step_i};
  assign rel_diff = {1'b0, level} - {1'b0, bus.release_step_i};
  // bit 8 of the differences flags an underflow below zero
  assign att_full = bus.attack_step_i == 8'd0 || att_sum[8] || &att_sum[7:0];
  assign dec_done = bus.decay_step_i == 8'd0 || dec_diff[8] || dec_diff[7:0] <= bus.sustain_lvl_i;
  assign rel_done = bus.release_step_i == 8'd0 || rel_diff[8] || rel_diff[7:0] == 8'd0;
  assign prod     = {9'd0, level} * ({9'd0, bus.master_vol_i} + 17'd1);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt          <= '0;
      gate_q       <= 1'b0;
      state        <= IDLE;
      level        <= '0;
      bus.volume_o <= '0;
      bus.active_o <= 1'b0;
      bus.state_o  <= '0;
    end else begin
      cnt          <= tick ? '0 : cnt + 1'b1;
      gate_q       <= bus.gate_i;
      state        <= state_n;
      level        <= level_n;
      bus.volume_o <= prod[15:8];
      bus.active_o <= state != IDLE;
      bus.state_o  <= state;
    end
  end
  // gate edges take priority over a coincident tick
  always_comb begin
    state_n = state;
    level_n = level;
    if (rise) state_n = ATTACK;
    else if (fall && state inside {ATTACK, DECAY, SUSTAIN}) state_n = RELEASE;
    else if (tick) begin
      case (state)
        ATTACK: begin
          level_n = att_full ? 8'hff : att_sum[7:0];
          state_n = att_full ? DECAY : ATTACK;
        end
        DECAY: begin
          level_n = dec_done ? bus.sustain_lvl_i : dec_diff[7:0];
          state_n = dec_done ? SUSTAIN : DECAY;
        end
        SUSTAIN: level_n = bus.sustain_lvl_i;
        RELEASE: begin
          level_n = rel_done ? 8'd0 : rel_diff[7:0];
          state_n = rel_done ? IDLE : RELEASE;
        end
        default: level_n = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_adsr_envelope.sv
// tb_adsr_envelope: randomized and directed checks against a behavioural ADSR model
module tb_adsr_envelope;
  localparam int TD = 20;
  logic clk = 0;
  logic rst_ni = 1;
  int checks = 0;
  int errors = 0;
  int got[$];
  int exp_q[$];
  bit cmp_en = 0;
  int m_st, m_lv, m_gq, m_cnt, m_vol, m_act, m_sto;
  adsr_envelope_if bus();
  adsr_envelope #(.CLK_MHZ(1), .TICK_HZ(1_000_000 / TD)) dut (.clk_i(clk), .rst_ni(rst_ni), .bus(bus));
  always #5 clk = ~clk;
  function automatic int imax(int a, int b); return a > b ? a : b; endfunction
  function automatic int imin(int a, int b); return a < b ? a : b; endfunction
  // returns next_state*256 + next_level, phases numbered 0..4 as IDLE..RELEASE
  function automatic int nxt(int st, int lv, int g, int gq, bit tk, int a, int d, int s, int r);
    int ns = st, nl = lv;
    if (g == 1 && gq == 0) ns = 1;
    else if (g == 0 && gq == 1 && st >= 1 && st <= 3) ns = 4;
    else if (tk) begin
      if (st == 0) nl = 0;
      else if (st == 1) begin
        nl = (a == 0) ? 255 : imin(lv + a, 255);
        if (nl == 255) ns = 2;
      end else if (st == 2) begin
        nl = (d == 0) ? s : imax(lv - d, s);
        if (nl <= s) begin nl = s; ns = 3; end
      end else if (st == 3) nl = s;
      else begin
        nl = (r == 0) ? 0 : imax(lv - r, 0);
        if (nl == 0) ns = 0;
      end
    end
    return ns * 256 + nl;
  endfunction
  always @(posedge clk or negedge rst_ni) begin
    int n;
    if (!rst_ni) begin
      m_st <= 0; m_lv <= 0; m_gq <= 0; m_cnt <= 0; m_vol <= 0; m_act <= 0; m_sto <= 0;
    end else begin
      n = nxt(m_st, m_lv, int'(bus.gate_i), m_gq, m_cnt == TD - 1, int'(bus.attack_step_i),
              int'(bus.decay_step_i), int'(bus.sustain_lvl_i), int'(bus.release_step_i));
      m_st  <= n / 256;
      m_lv  <= n % 256;
      m_cnt <= (m_cnt == TD - 1) ? 0 : m_cnt + 1;
      m_gq  <= int'(bus.gate_i);
      m_vol <= (m_lv * (int'(bus.master_vol_i) + 1)) / 256;
      m_act <= (m_st != 0) ? 1 : 0;
      m_sto <= m_st;
    end
  end
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (rst_ni && cmp_en) begin
    chk("model_volume", int'(bus.volume_o), m_vol);
    chk("model_active", int'(bus.active_o), m_act);
    chk("model_state", int'(bus.state_o), m_sto);
  end
  task automatic do_reset();
    @(negedge clk); rst_ni = 0;
    repeat (2) @(negedge clk); rst_ni = 1;
  endtask
  task automatic collect(input int n, input int lim);
    int last = int'(bus.volume_o);
    got.delete();
    for (int c = 0; c < lim && got.size() < n; c++) begin
      @(negedge clk);
      if (int'(bus.volume_o) != last) begin last = int'(bus.volume_o); got.push_back(last); end
    end
  endtask
  task automatic chk_seq(input string nm);
    for (int i = 0; i < exp_q.size(); i++) chk(nm, i < got.size() ? got[i] : -1, exp_q[i]);
  endtask
  task automatic wait_vol(input int v, input int lim);
    for (int c = 0; c < lim && int'(bus.volume_o) != v; c++) @(negedge clk);
    chk("wait_volume", int'(bus.volume_o), v);
  endtask
  task automatic wait_state(input int s, input int lim);
    for (int c = 0; c < lim && int'(bus.state_o) != s; c++) @(negedge clk);
    chk("wait_state", int'(bus.state_o), s);
  endtask
  task automatic set_shape(input int a, input int d, input int s, input int r, input int m);
    bus.attack_step_i = 8'(a); bus.decay_step_i = 8'(d); bus.sustain_lvl_i = 8'(s);
    bus.release_step_i = 8'(r); bus.master_vol_i = 8'(m);
  endtask
  function automatic int rstep();
    return ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
  endfunction
  initial begin
    bus.gate_i = 1;
    set_shape(51, 17, 136, 34, 255);
    #2 rst_ni = 0;
    cmp_en = 1;
    #1;
    chk("reset_volume", int'(bus.volume_o), 0);
    chk("reset_active", int'(bus.active_o), 0);
    chk("reset_state", int'(bus.state_o), 0);
    repeat (2) @(negedge clk); rst_ni = 1;
    repeat (2) @(negedge clk);
    chk("gate_high_at_release", int'(bus.state_o), 1);
    bus.gate_i = 0;
    do_reset();
    bus.gate_i = 1;
    collect(12, 20 * TD);
    exp_q = '{51, 102, 153, 204, 255, 238, 221, 204, 187, 170, 153, 136};
    chk_seq("adsr_rise");
    repeat (8 * TD) @(negedge clk);
    chk("sustain_volume", int'(bus.volume_o), 136);
    chk("sustain_state", int'(bus.state_o), 3);
    bus.gate_i = 0;
    collect(4, 6 * TD);
    exp_q = '{102, 68, 34, 0};
    chk_seq("adsr_release");
    repeat (3) @(negedge clk);
    chk("idle_active", int'(bus.active_o), 0);
    chk("idle_state", int'(bus.state_o), 0);
    do_reset();
    bus.gate_i = 1;
    wait_vol(153, 10 * TD);
    #2 rst_ni = 0;
    #1;
    chk("async_rst_volume", int'(bus.volume_o), 0);
    chk("async_rst_state", int'(bus.state_o), 0);
    chk("async_rst_active", int'(bus.active_o), 0);
    bus.gate_i = 0;
    @(negedge clk); rst_ni = 1;
    bus.gate_i = 1;
    wait_state(3, 20 * TD);
    bus.gate_i = 0;
    wait_vol(68, 10 * TD);
    bus.gate_i = 1;
    collect(4, 6 * TD);
    exp_q = '{119, 170, 221, 255};
    chk_seq("retrigger");
    bus.gate_i = 0;
    set_shape(0, 0, 200, 0, 255);
    do_reset();
    bus.gate_i = 1;
    collect(2, 4 * TD);
    exp_q = '{255, 200};
    chk_seq("instant_rise");
    bus.gate_i = 0;
    collect(1, 3 * TD);
    exp_q = '{0};
    chk_seq("instant_release");
    repeat (3) @(negedge clk);
    chk("instant_idle", int'(bus.state_o), 0);
    set_shape(0, 0, 255, 0, 255);
    bus.gate_i = 1;
    wait_state(3, 5 * TD);
    @(negedge clk);
    chk("master_255", int'(bus.volume_o), 255);
    bus.master_vol_i = 8'd127;
    @(negedge clk);
    chk("master_127", int'(bus.volume_o), 127);
    bus.master_vol_i = 8'd0;
    @(negedge clk);
    chk("master_0", int'(bus.volume_o), 0);
    bus.gate_i = 0;
    set_shape(51, 17, 136, 34, 255);
    do_reset();
    bus.gate_i = 1;
    wait_state(3, 20 * TD);
    bus.sustain_lvl_i = 8'd50;
    wait_vol(50, 2 * TD + 2);
    chk("sustain_edit_state", int'(bus.state_o), 3);
    for (int seg = 0; seg < 80; seg++) begin
      @(negedge clk);
      if ($urandom_range(0, 2) == 0)
        set_shape(rstep(), rstep(), int'($urandom_range(0, 255)), rstep(), int'($urandom_range(0, 255)));
      bus.gate_i = ~bus.gate_i;
      repeat (($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(1, 8 * TD)) @(negedge clk);
    end
    bus.gate_i = 0;
    repeat (3 * TD) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
